binary_tree_cmd_scheduler: RTL and testbench
============================================

Name: binary_tree_cmd_scheduler

Overview:
Command scheduler in front of binary_tree_8_64_seq.
- Collects per-input distribution requests (data word + 8-bit destination mask) from 8 requesters.
- Each cycle it issues a conflict-free set of requests, so no two inputs target the same output position of a fanout group.
- Drives the tree's i_valid / i_data_bus / i_cmd directly, with round-robin fairness and a flush/drain sequence.

Parameters:
NUM_INPUT_DATA, 8, number of requesters / tree inputs (power of 2)
NUM_OUTPUT_DATA, 8, destination mask width per input
DATA_WIDTH, 32, data word width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_en  in  1  issue enable; low = hold all state, issue nothing
i_flush  in  1  pulse: stop accepting, drain pending requests
i_req_valid  in  NUM_INPUT_DATA  per-input request valid
i_req_dst  in  NUM_INPUT_DATA*NUM_OUTPUT_DATA  destination mask; input i at [i*NUM_OUTPUT_DATA +: NUM_OUTPUT_DATA]
i_req_data  in  NUM_INPUT_DATA*DATA_WIDTH  data; input i at [i*DATA_WIDTH +: DATA_WIDTH]
o_req_ready  out  NUM_INPUT_DATA  per-input accept
o_valid  out  NUM_INPUT_DATA  to tree i_valid
o_data_bus  out  NUM_INPUT_DATA*DATA_WIDTH  to tree i_data_bus
o_cmd  out  NUM_INPUT_DATA*NUM_OUTPUT_DATA  to tree i_cmd
o_busy  out  1  any request held
o_flush_done  out  1  one-cycle pulse when drain completes
o_err_zero_dst  out  1  one-cycle pulse: request with all-zero mask dropped

Behaviour:
- Reset: all hold slots empty; rr pointer = 0; state IDLE. o_valid, o_data_bus, o_cmd, o_flush_done and o_err_zero_dst are 0. o_busy = 0.
- Storage: one hold slot per input (valid, mask, data).
- Handshake: o_req_ready[i] = ~hold_v[i] | grant[i], forced 0 in DRAIN and while rst.
  - Capture occurs on an edge where i_req_valid[i] & o_req_ready[i].
  - A zero mask is not stored; o_err_zero_dst pulses the next cycle.
- Arbitration (combinational from hold slots, only when i_en):
  - Scan inputs in order ptr, ptr+1, … mod N.
  - Slot i is granted if hold_v[i] and (mask_i & acc) == 0, where acc is the OR of masks already granted this cycle.
  - Multicast masks are allowed.
- Issue: on the grant edge, register o_valid[i] = grant[i]. o_data_bus/o_cmd fields take the granted slot contents; non-granted fields are 0. Granted slots free on the same edge.
- Latency: request captured at edge k → earliest o_valid after edge k+1. Outputs are valid for exactly one cycle per grant.
- rr pointer: on any grant, ptr ← (lowest-scan-order granted index + 1) mod N. Unchanged otherwise.
- i_en low:
  - grant = 0 and o_valid = 0 next cycle; slots hold.
  - Capture into empty slots is still allowed.
- FSM:
  - IDLE: no slot valid. Goes to ARB on any capture, or to DONE on i_flush.
  - ARB: slots pending. Goes to IDLE when all slots empty and there is no capture that edge; goes to DRAIN on i_flush.
  - DRAIN: ready = 0; continues issuing. Goes to DONE when all slots are empty after the issue edge.
  - DONE: single cycle, o_flush_done = 1, then IDLE.
- i_flush and a capture on the same edge: the capture is accepted, then the FSM enters DRAIN.
- i_flush during DRAIN/DONE is ignored.
- rst mid-operation: all held requests are discarded; no output is generated for them.
- Starvation bound: a blocked slot is granted within N arbitration cycles while i_en stays high.

Optional Feature:
BT_SCHED_STATS_EN
- Defined: adds output o_conflict_cnt [15:0], a saturating count at 16'hFFFF. It increments once per enabled cycle in which at least one valid slot was denied due to mask overlap, and is cleared by rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Setup for all scenarios: ptr = 0, i_en = 1.
- Multicast, no conflict: inputs 7/6/5 masks 8'b10010000 / 8'b00100000 / 8'b01000100, data ff../ee../dd.. in one cycle → next cycle o_valid = 8'b11100000, o_cmd = {8'b10010000, 8'b00100000, 8'b01000100, 40'b0}; ptr = 6.
- Conflict: inputs 7/6/5 masks 8'b10010000 / 8'b00100000 / 8'b00100010 →
  - cycle 1: o_valid = 8'b10100000, field 5 = 8'b00100010.
  - cycle 2: o_valid = 8'b01000000, o_cmd[55:48] = 8'b00100000.
- Fairness: inputs 0 and 1 both continuously request mask 8'b00000001 → grants alternate 0, 1, 0, 1; neither ready stays low for more than 2 cycles.
- Enable/zero-mask:
  - i_en = 0 with input 3 pending → o_valid stays 0.
  - Raise i_en → o_valid = 8'b00001000 the next cycle.
  - Input 2 mask 8'h00 → o_err_zero_dst pulses and no issue occurs.
- Flush: 3 conflicting requests on mask 8'b00000001 (inputs 0, 1, 2), then pulse i_flush →
  - o_req_ready = 0 during DRAIN.
  - Issues occur over 3 cycles.
  - o_flush_done pulses one cycle after the last issue, then o_busy = 0.
- Reset mid-drain: assert rst with 2 slots pending → next cycle o_valid = 0, o_busy = 0, state IDLE, ptr = 0.
  - With BT_SCHED_STATS_EN: o_conflict_cnt = 0.

Source files
------------

// File: rtl/binary_tree_cmd_scheduler_if.sv
// Request/issue bundle between requesters, binary_tree_cmd_scheduler and the tree.
// BT_SCHED_STATS_EN adds the o_conflict_cnt statistics signal.
interface binary_tree_cmd_scheduler_if #(
  parameter int NUM_INPUT_DATA  = 8,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int DATA_WIDTH      = 32
);
  logic                                  i_en;
  logic                                  i_flush;
  logic [NUM_INPUT_DATA-1:0]             i_req_valid;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] i_req_dst;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  i_req_data;
  logic [NUM_INPUT_DATA-1:0]             o_req_ready;
  logic [NUM_INPUT_DATA-1:0]             o_valid;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  o_data_bus;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] o_cmd;
  logic                                  o_busy;
  logic                                  o_flush_done;
  logic                                  o_err_zero_dst;
`ifdef BT_SCHED_STATS_EN
  logic [15:0]                           o_conflict_cnt;
`endif

  modport slave (
    input  i_en, i_flush, i_req_valid, i_req_dst, i_req_data,
    output o_req_ready, o_valid, o_data_bus, o_cmd,
`ifdef BT_SCHED_STATS_EN
    output o_conflict_cnt,
`endif
    output o_busy, o_flush_done, o_err_zero_dst
  );

  modport master (
    output i_en, i_flush, i_req_valid, i_req_dst, i_req_data,
    input  o_req_ready, o_valid, o_data_bus, o_cmd,
`ifdef BT_SCHED_STATS_EN
    input  o_conflict_cnt,
`endif
    input  o_busy, o_flush_done, o_err_zero_dst
  );
endinterface

// File: rtl/binary_tree_cmd_scheduler.sv
// Conflict-free round-robin command scheduler feeding binary_tree_8_64_seq.
// Optional BT_SCHED_STATS_EN adds a saturating mask-conflict counter.
//
// state | meaning
// IDLE  | no request held
// ARB   | requests pending, accepting and issuing
// DRAIN | flush in progress: no accepts, issue until empty
// DONE  | drain complete, o_flush_done for one cycle
module binary_tree_cmd_scheduler #(
  parameter int NUM_INPUT_DATA  = 8,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int DATA_WIDTH      = 32
) (
  input logic clk,
  input logic rst,
  binary_tree_cmd_scheduler_if.slave bus
);
  localparam int N  = NUM_INPUT_DATA;
  localparam int M  = NUM_OUTPUT_DATA;
  localparam int W  = DATA_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ARB, DRAIN, DONE} state_t;

  state_t         state, state_n;
  logic [N-1:0]   hold_v;
  logic [M-1:0]   hold_mask [N];
  logic [W-1:0]   hold_data [N];
  logic [N-1:0]   grant, ready, cap, store, zero_dst;
  logic [M-1:0]   acc;
  logic [PW-1:0]  ptr, first_idx, idx;
  logic           found;
  logic [N-1:0]   valid_q;
  logic [N*W-1:0] data_q;
  logic [N*M-1:0] cmd_q;
  logic           err_q;

  always_comb begin
    zero_dst = '0;
    for (int i = 0; i < N; i++) begin
      zero_dst[i] = (bus.i_req_dst[i*M +: M] == '0);
    end
  end

  assign ready = (~hold_v | grant) & {N{(state != DRAIN) && !rst}};
  assign cap   = bus.i_req_valid & ready;
  assign store = cap & ~zero_dst;

  // Greedy scan from ptr: a slot wins if its mask is disjoint from all earlier winners.
  always_comb begin
    grant     = '0;
    acc       = '0;
    found     = 1'b0;
    first_idx = '0;
    idx       = '0;
    if (bus.i_en && !rst) begin
      for (int k = 0; k < N; k++) begin
        idx = ptr + PW'(k);
        if (hold_v[idx] && ((hold_mask[idx] & acc) == '0)) begin
          grant[idx] = 1'b1;
          acc        = acc | hold_mask[idx];
          if (!found) begin
            found     = 1'b1;
            first_idx = idx;
          end
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.i_flush)  state_n = (|store) ? DRAIN : DONE;
        else if (|store)  state_n = ARB;
      end
      ARB: begin
        if (bus.i_flush)                                   state_n = DRAIN;
        else if (((hold_v & ~grant) | store) == '0)        state_n = IDLE;
      end
      DRAIN: begin
        if ((hold_v & ~grant) == '0) state_n = DONE;
      end
      DONE:    state_n = (|store) ? ARB : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v  <= '0;
      ptr     <= '0;
      valid_q <= '0;
      data_q  <= '0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        hold_mask[i] <= '0;
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (store[i]) begin
          hold_v[i]    <= 1'b1;
          hold_mask[i] <= bus.i_req_dst[i*M +: M];
          hold_data[i] <= bus.i_req_data[i*W +: W];
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
        data_q[i*W +: W] <= grant[i] ? hold_data[i] : '0;
        cmd_q[i*M +: M]  <= grant[i] ? hold_mask[i] : '0;
      end
      valid_q <= grant;
      err_q   <= |(cap & zero_dst);
      if (found) ptr <= first_idx + PW'(1);
    end
  end

`ifdef BT_SCHED_STATS_EN
  logic        conflict;
  logic [15:0] conflict_cnt;

  // When enabled, a held slot that is not granted lost on mask overlap.
  assign conflict = bus.i_en && !rst && (|(hold_v & ~grant));

  always_ff @(posedge clk) begin
    if (rst)                                        conflict_cnt <= '0;
    else if (conflict && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
  end

  assign bus.o_conflict_cnt = conflict_cnt;
`endif

  assign bus.o_req_ready    = ready;
  assign bus.o_valid        = valid_q;
  assign bus.o_data_bus     = data_q;
  assign bus.o_cmd          = cmd_q;
  assign bus.o_busy         = |hold_v;
  assign bus.o_flush_done   = (state == DONE);
  assign bus.o_err_zero_dst = err_q;
endmodule

// File: tb/tb_binary_tree_cmd_scheduler.sv
// Directed self-checking bench for binary_tree_cmd_scheduler (8 inputs, 8-bit masks, 32-bit data).
module tb_binary_tree_cmd_scheduler;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  binary_tree_cmd_scheduler_if bus ();

  binary_tree_cmd_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    bus.i_req_valid = '0;
    bus.i_req_dst   = '0;
    bus.i_req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic [7:0] m, input logic [31:0] d);
    bus.i_req_valid[i]      = 1'b1;
    bus.i_req_dst[i*8 +: 8] = m;
    bus.i_req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    clr_req();
    bus.i_flush = 1'b0;
    bus.i_en    = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.i_en    = 1'b1;
    bus.i_flush = 1'b0;
    clr_req();
    tick();
    tick();

    // reset state
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_cmd", bus.o_cmd, 0);
    chk("rst_data", bus.o_data_bus, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_flush_done", bus.o_flush_done, 0);
    chk("rst_err", bus.o_err_zero_dst, 0);
    chk("rst_ready_low", bus.o_req_ready, 0);
`ifdef BT_SCHED_STATS_EN
    chk("rst_cnt", bus.o_conflict_cnt, 0);
`endif
    rst = 1'b0;
    tick();
    chk("post_rst_ready", bus.o_req_ready, 8'hFF);

    // multicast without conflict
    do_reset();
    set_req(7, 8'b10010000, 32'hFFFFFFFF);
    set_req(6, 8'b00100000, 32'hEEEEEEEE);
    set_req(5, 8'b01000100, 32'hDDDDDDDD);
    tick();
    clr_req();
    chk("mc_latency_valid", bus.o_valid, 0);
    chk("mc_busy", bus.o_busy, 1);
    tick();
    chk("mc_valid", bus.o_valid, 8'b11100000);
    chk("mc_cmd", bus.o_cmd, {8'b10010000, 8'b00100000, 8'b01000100, 40'b0});
    chk("mc_data", bus.o_data_bus, {32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 160'b0});
    tick();
    chk("mc_one_cycle", bus.o_valid, 0);
    chk("mc_idle_busy", bus.o_busy, 0);

    // conflict between inputs 5 and 6
    do_reset();
    set_req(7, 8'b10010000, 32'hFFFFFFFF);
    set_req(6, 8'b00100000, 32'hEEEEEEEE);
    set_req(5, 8'b00100010, 32'hDDDDDDDD);
    tick();
    clr_req();
    tick();
    chk("cf_c1_valid", bus.o_valid, 8'b10100000);
    chk("cf_c1_cmd", bus.o_cmd, {8'b10010000, 8'b0, 8'b00100010, 40'b0});
`ifdef BT_SCHED_STATS_EN
    chk("cf_cnt1", bus.o_conflict_cnt, 1);
`endif
    tick();
    chk("cf_c2_valid", bus.o_valid, 8'b01000000);
    chk("cf_c2_cmd", bus.o_cmd, {8'b0, 8'b00100000, 48'b0});
    chk("cf_c2_data", bus.o_data_bus, {32'b0, 32'hEEEEEEEE, 192'b0});
`ifdef BT_SCHED_STATS_EN
    chk("cf_cnt2", bus.o_conflict_cnt, 1);
`endif

    // fairness: inputs 0 and 1 contend for output 0 continuously
    do_reset();
    set_req(0, 8'b00000001, 32'h0A0A0A0A);
    set_req(1, 8'b00000001, 32'h1B1B1B1B);
    tick();
    chk("fair_ready0", bus.o_req_ready, 8'b11111101);
    tick();
    chk("fair_g0_valid", bus.o_valid, 8'b00000001);
    chk("fair_g0_data", bus.o_data_bus, 256'h0A0A0A0A);
    chk("fair_ready1", bus.o_req_ready, 8'b11111110);
    tick();
    chk("fair_g1_valid", bus.o_valid, 8'b00000010);
    chk("fair_ready2", bus.o_req_ready, 8'b11111101);
    tick();
    chk("fair_g2_valid", bus.o_valid, 8'b00000001);
    chk("fair_ready3", bus.o_req_ready, 8'b11111110);
    tick();
    chk("fair_g3_valid", bus.o_valid, 8'b00000010);
    clr_req();

    // enable gating and zero-mask drop
    do_reset();
    bus.i_en = 1'b0;
    set_req(3, 8'h08, 32'h33333333);
    tick();
    clr_req();
    chk("en_ready_held", bus.o_req_ready, 8'b11110111);
    tick();
    chk("en_off_valid0", bus.o_valid, 0);
    chk("en_off_busy", bus.o_busy, 1);
    tick();
    chk("en_off_valid1", bus.o_valid, 0);
    bus.i_en = 1'b1;
    tick();
    chk("en_on_valid", bus.o_valid, 8'b00001000);
    chk("en_on_cmd", bus.o_cmd, {32'b0, 8'h08, 24'b0});
    chk("en_on_busy", bus.o_busy, 0);
    set_req(2, 8'h00, 32'h22222222);
    tick();
    clr_req();
    chk("zd_err", bus.o_err_zero_dst, 1);
    chk("zd_busy", bus.o_busy, 0);
    chk("zd_valid", bus.o_valid, 0);
    tick();
    chk("zd_err_pulse", bus.o_err_zero_dst, 0);
    chk("zd_no_issue", bus.o_valid, 0);

    // flush with three conflicting requests
    do_reset();
    set_req(0, 8'b00000001, 32'h00000010);
    set_req(1, 8'b00000001, 32'h00000011);
    set_req(2, 8'b00000001, 32'h00000012);
    tick();
    clr_req();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("fl_i0_valid", bus.o_valid, 8'b00000001);
    chk("fl_ready0", bus.o_req_ready, 0);
    chk("fl_done0", bus.o_flush_done, 0);
    chk("fl_busy0", bus.o_busy, 1);
    tick();
    chk("fl_i1_valid", bus.o_valid, 8'b00000010);
    chk("fl_ready1", bus.o_req_ready, 0);
    chk("fl_done1", bus.o_flush_done, 0);
    tick();
    chk("fl_i2_valid", bus.o_valid, 8'b00000100);
    chk("fl_done2", bus.o_flush_done, 1);
    chk("fl_busy2", bus.o_busy, 0);
    tick();
    chk("fl_done_pulse", bus.o_flush_done, 0);
    chk("fl_quiet", bus.o_valid, 0);
    chk("fl_ready_back", bus.o_req_ready, 8'hFF);

    // reset in the middle of a drain
    do_reset();
    set_req(0, 8'b00000001, 32'h00000020);
    set_req(1, 8'b00000001, 32'h00000021);
    set_req(2, 8'b00000001, 32'h00000022);
    tick();
    clr_req();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("rd_pending_busy", bus.o_busy, 1);
    chk("rd_drain_ready", bus.o_req_ready, 0);
    rst = 1'b1;
    tick();
    chk("rd_valid", bus.o_valid, 0);
    chk("rd_busy", bus.o_busy, 0);
    chk("rd_done", bus.o_flush_done, 0);
`ifdef BT_SCHED_STATS_EN
    chk("rd_cnt", bus.o_conflict_cnt, 0);
`endif
    rst = 1'b0;
    tick();
    chk("rd_no_issue", bus.o_valid, 0);
    chk("rd_ready", bus.o_req_ready, 8'hFF);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("rd_idle_flush_done", bus.o_flush_done, 1);
    tick();
    chk("rd_idle_flush_pulse", bus.o_flush_done, 0);
    set_req(7, 8'b00000001, 32'h77777777);
    set_req(0, 8'b00000001, 32'h00000099);
    tick();
    clr_req();
    tick();
    chk("rd_ptr_zero_first", bus.o_valid, 8'b00000001);
    tick();
    chk("rd_ptr_zero_second", bus.o_valid, 8'b10000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
